// File: rtl/score_board.sv
// Register-hazard tracker and dual-issue scheduler.
// Tracks the in-flight writer of every architectural register through the
// EX -> MEM -> CMT pipeline, reports per-source bypass selects and readiness,
// and decides how many of the two offered in-order instructions issue.
module score_board #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int SEL_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_wen,
    input  logic [1:0][ADDR_W-1:0] req_dst,
    input  logic [1:0]             req_is_load,
    input  logic [3:0]             req_src_used,
    input  logic [3:0][ADDR_W-1:0] req_src,
    output logic [3:0][SEL_W-1:0]  src_sel,
    output logic [3:0]             src_ready,
    output logic [1:0]             issue_grant,
    output logic [1:0]             issue_count
);

    typedef enum logic [1:0] {
        ST_EX   = 2'd0,
        ST_MEM  = 2'd1,
        ST_CMT  = 2'd2,
        ST_NONE = 2'd3
    } stage_t;

    // Per-register producer record (entry 0 is never written).
    logic   ent_valid_r [NUM_REGS];
    stage_t ent_stage_r [NUM_REGS];
    logic   ent_lane_r  [NUM_REGS];
    logic   ent_load_r  [NUM_REGS];

    logic   nxt_valid_s [NUM_REGS];
    stage_t nxt_stage_s [NUM_REGS];
    logic   nxt_lane_s  [NUM_REGS];
    logic   nxt_load_s  [NUM_REGS];

    logic   raw_s;
    logic   wr0_s;
    logic   wr1_s;

    // Producer lookup: translate each used source into a bypass select and readiness.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            src_sel[j]   = SEL_W'(0);
            src_ready[j] = 1'b1;
            if (req_src_used[j] && (req_src[j] != ADDR_W'(0)) && ent_valid_r[req_src[j]]) begin
                case (ent_stage_r[req_src[j]])
                    ST_EX: begin
                        // A load still in EX has no data yet: load-use stall.
                        src_sel[j]   = ent_lane_r[req_src[j]] ? SEL_W'(2) : SEL_W'(1);
                        src_ready[j] = ~ent_load_r[req_src[j]];
                    end
                    ST_MEM: begin
                        src_sel[j]   = ent_lane_r[req_src[j]] ? SEL_W'(4) : SEL_W'(3);
                        src_ready[j] = 1'b1;
                    end
                    ST_CMT: begin
                        src_sel[j]   = ent_lane_r[req_src[j]] ? SEL_W'(6) : SEL_W'(5);
                        src_ready[j] = 1'b1;
                    end
                    default: begin
                        src_sel[j]   = SEL_W'(0);
                        src_ready[j] = 1'b1;
                    end
                endcase
            end else begin
                src_sel[j]   = SEL_W'(0);
                src_ready[j] = 1'b1;
            end
        end
    end

    // In-order issue decision; lane1 also blocked by a RAW on lane0's destination.
    always_comb begin
        raw_s = req_wen[0] && (req_dst[0] != ADDR_W'(0)) &&
                ((req_src_used[2] && (req_src[2] == req_dst[0])) ||
                 (req_src_used[3] && (req_src[3] == req_dst[0])));
        issue_grant[0] = req_valid[0] & src_ready[0] & src_ready[1];
        issue_grant[1] = issue_grant[0] & req_valid[1] & src_ready[2] & src_ready[3] & ~raw_s;
        issue_count    = {1'b0, issue_grant[0]} + {1'b0, issue_grant[1]};
        wr0_s          = issue_grant[0] && req_wen[0] && (req_dst[0] != ADDR_W'(0));
        wr1_s          = issue_grant[1] && req_wen[1] && (req_dst[1] != ADDR_W'(0));
    end

    // Next table state: a new write (lane1 over lane0) beats the advancing entry.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            nxt_valid_s[r] = 1'b0;
            nxt_stage_s[r] = ST_EX;
            nxt_lane_s[r]  = ent_lane_r[r];
            nxt_load_s[r]  = ent_load_r[r];
            if (wr1_s && (req_dst[1] == ADDR_W'(r))) begin
                nxt_valid_s[r] = 1'b1;
                nxt_stage_s[r] = ST_EX;
                nxt_lane_s[r]  = 1'b1;
                nxt_load_s[r]  = req_is_load[1];
            end else if (wr0_s && (req_dst[0] == ADDR_W'(r))) begin
                nxt_valid_s[r] = 1'b1;
                nxt_stage_s[r] = ST_EX;
                nxt_lane_s[r]  = 1'b0;
                nxt_load_s[r]  = req_is_load[0];
            end else if (ent_valid_r[r]) begin
                case (ent_stage_r[r])
                    ST_EX: begin
                        nxt_valid_s[r] = 1'b1;
                        nxt_stage_s[r] = ST_MEM;
                    end
                    ST_MEM: begin
                        nxt_valid_s[r] = 1'b1;
                        nxt_stage_s[r] = ST_CMT;
                    end
                    default: begin
                        // CMT retires into the regfile; anything else is dropped.
                        nxt_valid_s[r] = 1'b0;
                        nxt_stage_s[r] = ST_NONE;
                    end
                endcase
            end else begin
                nxt_valid_s[r] = 1'b0;
                nxt_stage_s[r] = ST_NONE;
            end
        end
    end

    // Table registers; reset and flush empty the table and override same-cycle writes.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst || flush) begin
                ent_valid_r[r] <= 1'b0;
                ent_stage_r[r] <= ST_NONE;
                ent_lane_r[r]  <= 1'b0;
                ent_load_r[r]  <= 1'b0;
            end else begin
                ent_valid_r[r] <= nxt_valid_s[r];
                ent_stage_r[r] <= nxt_stage_s[r];
                ent_lane_r[r]  <= nxt_lane_s[r];
                ent_load_r[r]  <= nxt_load_s[r];
            end
        end
    end

endmodule

// File: tb/tb_score_board.sv
// Scoreboard bench for score_board: the driver computes the expected response
// from an age-based reference model and queues it; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_score_board;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      req_valid;
    logic [1:0]      req_wen;
    logic [1:0][4:0] req_dst;
    logic [1:0]      req_is_load;
    logic [3:0]      req_src_used;
    logic [3:0][4:0] req_src;
    logic [3:0][2:0] src_sel;
    logic [3:0]      src_ready;
    logic [1:0]      issue_grant;
    logic [1:0]      issue_count;

    always #5 clk = ~clk;

    score_board dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_wen      (req_wen),
        .req_dst      (req_dst),
        .req_is_load  (req_is_load),
        .req_src_used (req_src_used),
        .req_src      (req_src),
        .src_sel      (src_sel),
        .src_ready    (src_ready),
        .issue_grant  (issue_grant),
        .issue_count  (issue_count)
    );

    typedef struct packed {
        logic [3:0][2:0] sel;
        logic [3:0]      rdy;
        logic [1:0]      gnt;
        logic [1:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: for each register, the clock edge at which its newest
    // writer entered EX. Age 0/1/2 after that edge = EX/MEM/CMT, later = regfile.
    int   issue_edge [32];
    int   m_lane     [32];
    bit   m_load     [32];
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("src_sel",     32'(src_sel),     32'(e.sel));
            check("src_ready",   32'(src_ready),   32'(e.rdy));
            check("issue_grant", 32'(issue_grant), 32'(e.gnt));
            check("issue_count", 32'(issue_count), 32'(e.cnt));
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [4:0] d0, input logic [4:0] d1,
                         input logic [1:0] ld, input logic [3:0] u,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] s3,
                         input logic f, input logic r);
        logic [4:0] s [4];
        exp_t       e;
        int         age;
        logic       raw;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        req_valid    = v;
        req_wen      = w;
        req_dst[0]   = d0;
        req_dst[1]   = d1;
        req_is_load  = ld;
        req_src_used = u;
        for (int j = 0; j < 4; j++) req_src[j] = s[j];
        flush = f;
        rst   = r;
        for (int j = 0; j < 4; j++) begin
            e.sel[j] = 3'd0;
            e.rdy[j] = 1'b1;
            if (u[j] && s[j] != 5'd0) begin
                age = cyc - issue_edge[s[j]];
                if (age >= 0 && age <= 2) begin
                    e.sel[j] = 3'(1 + 2 * age + m_lane[s[j]]);
                    e.rdy[j] = !(age == 0 && m_load[s[j]]);
                end
            end
        end
        raw = w[0] && d0 != 5'd0 && ((u[2] && s2 == d0) || (u[3] && s3 == d0));
        e.gnt[0] = v[0] && e.rdy[0] && e.rdy[1];
        e.gnt[1] = e.gnt[0] && v[1] && e.rdy[2] && e.rdy[3] && !raw;
        e.cnt    = 2'(e.gnt[0]) + 2'(e.gnt[1]);
        exp_q.push_back(e);
        @(posedge clk);
        cyc++;
        if (r || f) begin
            for (int k = 0; k < 32; k++) issue_edge[k] = -100;
        end else begin
            if (e.gnt[0] && w[0] && d0 != 5'd0) begin
                issue_edge[d0] = cyc; m_lane[d0] = 0; m_load[d0] = ld[0];
            end
            if (e.gnt[1] && w[1] && d1 != 5'd0) begin
                issue_edge[d1] = cyc; m_lane[d1] = 1; m_load[d1] = ld[1];
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 2'b00; req_wen = 2'b00;
        req_dst = '0; req_is_load = 2'b00; req_src_used = 4'b0000; req_src = '0;
        for (int k = 0; k < 32; k++) begin
            issue_edge[k] = -100; m_lane[k] = 0; m_load[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Independent pair, then watch r3/r4 walk EX -> MEM -> CMT -> regfile.
        drive(2'b11, 2'b11, 5'd3, 5'd4, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (4) drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0011, 5'd3, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        // Load-use on r5.
        drive(2'b01, 2'b01, 5'd5, 5'd0, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0001, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // Intra-pair RAW on r7, then lane1 re-presented as lane0.
        drive(2'b11, 2'b01, 5'd7, 5'd0, 2'b00, 4'b0100, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0001, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // WAW on r9, then rewrite while the old entry is in MEM.
        drive(2'b11, 2'b11, 5'd9, 5'd9, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0001, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b01, 5'd9, 5'd0, 2'b00, 4'b0001, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0001, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // Lane0 load-use blocked while lane1 is independent: nothing issues.
        drive(2'b01, 2'b01, 5'd10, 5'd0, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0101, 5'd10, 5'd0, 5'd11, 5'd0, 1'b0, 1'b0);
        // r6 in MEM, r2 in EX, flush (with a same-cycle write to r8 that must be lost).
        drive(2'b01, 2'b01, 5'd6, 5'd0, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b01, 5'd2, 5'd0, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b01, 5'd8, 5'd0, 2'b00, 4'b0011, 5'd2, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
        drive(2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 4'b1111, 5'd2, 5'd6, 5'd8, 5'd2, 1'b0, 1'b0);
        // Writes to r0 are never tracked.
        drive(2'b11, 2'b11, 5'd0, 5'd0, 2'b11, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 4'b1111, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // Mid-run reset clears the table.
        drive(2'b01, 2'b01, 5'd12, 5'd0, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0001, 5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        drive(2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 4'b0001, 5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // Random traffic over a small register pool to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            drive(2'($urandom), 2'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                  4'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
        end
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
